predictor_saltos: RTL and testbench

PREDICTOR_SALTOS -- requirements
Module: predictor_saltos

---
 rtl/predictor_pkg.sv | 28 ++
 rtl/predictor_saltos_if.sv | 31 +++
 rtl/contador_saturacion.sv | 19 +
 rtl/predictor_saltos.sv | 101 ++++++++++
 tb/tb_predictor_saltos.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/predictor_pkg.sv
// rtl/predictor_pkg.sv - shared types for the branch target buffer predictor
package predictor_pkg;

  localparam int ENTRIES_DEFAULT = 16;
  // Widest tag needed: the smallest table (4 entries) leaves 28 PC bits above the index.
  localparam int TAG_W = 28;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } contador_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    contador_e        counter;
  } btb_entry_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc, input int idx_w);
    logic [31:0] sh;
    sh = pc >> (idx_w + 2);
    return sh[TAG_W-1:0];
  endfunction

endpackage

// File: rtl/predictor_saltos_if.sv
// rtl/predictor_saltos_if.sv - fetch lookup and EX resolution bundle between pipeline and predictor
interface predictor_saltos_if;

  logic        pcf;
  logic [31:0] pcf_addr;
  logic        hitf;
  logic [1:0]  prediccionf;
  logic        selbpf;
  logic [31:0] pcbpf;
  logic        branche;
  logic        takene;
  logic [31:0] targete;
  logic [31:0] pce;
  logic [31:0] pcplus4e;
  logic        hite;
  logic [1:0]  prediccione;
  logic        selbpe;
  logic        flush;
  logic [31:0] pcfix;

  modport master (
    output pcf_addr, branche, takene, targete, pce, pcplus4e, hite, prediccione, selbpe,
    input  hitf, prediccionf, selbpf, pcbpf, flush, pcfix
  );

  modport slave (
    input  pcf_addr, branche, takene, targete, pce, pcplus4e, hite, prediccione, selbpe,
    output hitf, prediccionf, selbpf, pcbpf, flush, pcfix
  );

endinterface

// File: rtl/contador_saturacion.sv
// rtl/contador_saturacion.sv - next state of a 2-bit saturating direction counter
module contador_saturacion
  import predictor_pkg::*;
(
  input  contador_e cnt_i,
  input  logic      taken_i,
  output contador_e cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = contador_e'(cnt_i + 2'd1);
    end else begin
      if (cnt_i != SNT) cnt_o = contador_e'(cnt_i - 2'd1);
    end
  end

endmodule

// File: rtl/predictor_saltos.sv
// rtl/predictor_saltos.sv - direct-mapped BTB with 2-bit counters, EX-stage update and mispredict repair
module predictor_saltos
  import predictor_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] pcf_i,
  output logic        hitF_o,
  output logic [1:0]  prediccionF_o,
  output logic        selbpF_o,
  output logic [31:0] pcbpF_o,
  input  logic        branchE_i,
  input  logic        takenE_i,
  input  logic [31:0] targetE_i,
  input  logic [31:0] pce_i,
  input  logic [31:0] pcplus4e_i,
  input  logic        hitE_i,
  input  logic [1:0]  prediccionE_i,
  input  logic        selbpE_i,
  output logic        flush_o,
  output logic [31:0] pcfix_o,
  output logic [31:0] nbranch_o,
  output logic [31:0] nmiss_o
);

  localparam int IDX = $clog2(ENTRIES);

  btb_entry_t       btb_q [ENTRIES];
  logic [31:0]      nbranch_q;
  logic [31:0]      nmiss_q;

  logic [IDX-1:0]   idx_f;
  logic [IDX-1:0]   idx_e;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_e;
  btb_entry_t       ent_f;
  logic             hit_f;
  logic             mispredict;
  contador_e        cnt_upd;
  logic             we_d;
  btb_entry_t       entry_d;

  assign idx_f = pcf_i[IDX+1:2];
  assign tag_f = tag_of(pcf_i, IDX);
  assign idx_e = pce_i[IDX+1:2];
  assign tag_e = tag_of(pce_i, IDX);

  // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
  assign ent_f         = btb_q[idx_f];
  assign hit_f         = ent_f.valid && (ent_f.tag == tag_f);
  assign hitF_o        = hit_f;
  assign prediccionF_o = hit_f ? ent_f.counter : SNT;
  assign selbpF_o      = hit_f & ent_f.counter[1];
  assign pcbpF_o       = hit_f ? ent_f.target : 32'h0;

  assign mispredict = branchE_i ? (selbpE_i != takenE_i) : selbpE_i;
  assign flush_o    = mispredict;
  assign pcfix_o    = (branchE_i && takenE_i) ? targetE_i : pcplus4e_i;
  assign nbranch_o  = nbranch_q;
  assign nmiss_o    = nmiss_q;

  contador_saturacion u_sat (
    .cnt_i   (contador_e'(prediccionE_i)),
    .taken_i (takenE_i),
    .cnt_o   (cnt_upd)
  );

  always_comb begin
    we_d    = 1'b0;
    entry_d = btb_q[idx_e];
    if (branchE_i && hitE_i) begin
      we_d            = 1'b1;
      entry_d.counter = cnt_upd;
      entry_d.target  = targetE_i;
    end else if (branchE_i && takenE_i) begin
      we_d    = 1'b1;
      entry_d = '{valid: 1'b1, tag: tag_e, target: targetE_i, counter: WT};
    end else if (!branchE_i && hitE_i) begin
      // A non-branch that hit is an alias; drop the entry so it stops redirecting fetch.
      we_d          = 1'b1;
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, counter: WNT};
      end
      nbranch_q <= 32'h0;
      nmiss_q   <= 32'h0;
    end else begin
      if (we_d) btb_q[idx_e] <= entry_d;
      if (branchE_i) nbranch_q <= nbranch_q + 32'd1;
      if (mispredict) nmiss_q <= nmiss_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_predictor_saltos.sv
// tb/tb_predictor_saltos.sv - randomized self-checking bench for predictor_saltos against a table model
module tb_predictor_saltos;

  localparam int ENTRIES = 16;
  localparam int IDX     = 4;

  logic        clk;
  logic        reset_n;
  logic [31:0] nbranch;
  logic [31:0] nmiss;
  int          checks;
  int          errors;
  bit          chk_en;

  predictor_saltos_if bus ();

  predictor_saltos #(.ENTRIES(ENTRIES)) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .pcf_i         (bus.pcf_addr),
    .hitF_o        (bus.hitf),
    .prediccionF_o (bus.prediccionf),
    .selbpF_o      (bus.selbpf),
    .pcbpF_o       (bus.pcbpf),
    .branchE_i     (bus.branche),
    .takenE_i      (bus.takene),
    .targetE_i     (bus.targete),
    .pce_i         (bus.pce),
    .pcplus4e_i    (bus.pcplus4e),
    .hitE_i        (bus.hite),
    .prediccionE_i (bus.prediccione),
    .selbpE_i      (bus.selbpe),
    .flush_o       (bus.flush),
    .pcfix_o       (bus.pcfix),
    .nbranch_o     (nbranch),
    .nmiss_o       (nmiss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: plain arrays, tag kept as the full upper PC bits.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_nbranch;
  logic [31:0] m_nmiss;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> (IDX + 2)));
  endfunction

  function automatic bit m_flush(input bit br, input bit tk, input bit sel);
    return br ? (sel != tk) : sel;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 32'h0; m_tgt[i] = 32'h0; m_cnt[i] = 1;
      end
      m_nbranch = 32'h0;
      m_nmiss   = 32'h0;
    end else begin
      int k;
      k = m_idx(bus.pce);
      if (bus.branche) m_nbranch = m_nbranch + 1;
      if (m_flush(bus.branche, bus.takene, bus.selbpe)) m_nmiss = m_nmiss + 1;
      if (bus.branche && bus.hite) begin
        m_cnt[k] = bus.takene ? ((int'(bus.prediccione) == 3) ? 3 : int'(bus.prediccione) + 1)
                              : ((int'(bus.prediccione) == 0) ? 0 : int'(bus.prediccione) - 1);
        m_tgt[k] = bus.targete;
      end else if (bus.branche && bus.takene) begin
        m_valid[k] = 1'b1; m_tag[k] = bus.pce >> (IDX + 2); m_tgt[k] = bus.targete; m_cnt[k] = 2;
      end else if (!bus.branche && bus.hite) begin
        m_valid[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit          h;
      logic [31:0] p;
      h = m_hit(bus.pcf_addr);
      p = 32'(m_cnt[m_idx(bus.pcf_addr)]);
      chk("hitF", 32'(bus.hitf), 32'(h));
      chk("prediccionF", 32'(bus.prediccionf), h ? p : 32'h0);
      chk("selbpF", 32'(bus.selbpf), h ? 32'(p >= 2) : 32'h0);
      chk("pcbpF", bus.pcbpf, h ? m_tgt[m_idx(bus.pcf_addr)] : 32'h0);
      chk("flush", 32'(bus.flush), 32'(m_flush(bus.branche, bus.takene, bus.selbpe)));
      chk("pcfix", bus.pcfix, (bus.branche && bus.takene) ? bus.targete : bus.pcplus4e);
      chk("nbranch", nbranch, m_nbranch);
      chk("nmiss", nmiss, m_nmiss);
    end
  end

  task automatic drive(input logic [31:0] pcf, input logic br, input logic tk, input logic [31:0] tgt,
                       input logic [31:0] pce, input logic hit, input logic [1:0] pred, input logic sel);
    bus.pcf_addr    = pcf;
    bus.branche     = br;
    bus.takene      = tk;
    bus.targete     = tgt;
    bus.pce         = pce;
    bus.pcplus4e    = pce + 32'd4;
    bus.hite        = hit;
    bus.prediccione = pred;
    bus.selbpe      = sel;
  endtask

  task automatic step(input logic [31:0] pcf, input logic br, input logic tk, input logic [31:0] tgt,
                      input logic [31:0] pce, input logic hit, input logic [1:0] pred, input logic sel);
    @(posedge clk);
    #1;
    drive(pcf, br, tk, tgt, pce, hit, pred, sel);
    @(negedge clk);
  endtask

  logic [31:0] pool [8] = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h1000, 32'h2100, 32'h3c, 32'h7c0};

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      logic [31:0] pce, pcf;
      logic br, tk, hit, sel;
      logic [1:0] pred;
      pce = pool[$urandom_range(7)];
      pcf = ($urandom_range(15) == 0) ? $urandom : pool[$urandom_range(7)];
      @(posedge clk);
      #1;
      if ($urandom_range(7) == 0) begin
        drive(pcf, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
      end else begin
        br   = ($urandom_range(9) < 8);
        tk   = 1'($urandom);
        hit  = ($urandom_range(3) != 0) ? m_hit(pce) : 1'($urandom);
        pred = hit ? 2'(m_cnt[m_idx(pce)]) : 2'($urandom);
        sel  = ($urandom_range(4) != 0) ? (hit & pred[1]) : 1'($urandom);
        drive(pcf, br, tk, pool[$urandom_range(7)], pce, hit, pred, sel);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    chk_en  = 1'b1;
    reset_n = 1'b0;
    drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    step(32'h100, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0);
    chk("lit reset hitF", 32'(bus.hitf), 32'h0);
    chk("lit reset selbpF", 32'(bus.selbpf), 32'h0);
    chk("lit reset pcbpF", bus.pcbpf, 32'h0);

    step(32'h100, 1, 1, 32'h200, 32'h100, 0, 2'b00, 0);
    chk("lit alloc flush", 32'(bus.flush), 32'h1);
    chk("lit alloc pcfix", bus.pcfix, 32'h200);
    chk("lit alloc same-cycle hitF", 32'(bus.hitf), 32'h0);

    step(32'h100, 1, 1, 32'h200, 32'h100, 1, 2'b11, 1);
    chk("lit after alloc hitF", 32'(bus.hitf), 32'h1);
    chk("lit after alloc pred", 32'(bus.prediccionf), 32'h2);
    chk("lit after alloc selbp", 32'(bus.selbpf), 32'h1);
    chk("lit after alloc pcbp", bus.pcbpf, 32'h200);

    step(32'h100, 1, 0, 32'h200, 32'h100, 1, 2'b00, 0);
    chk("lit sat high", 32'(bus.prediccionf), 32'h3);
    chk("lit nt pcfix", bus.pcfix, 32'h104);

    step(32'h100, 1, 0, 32'h200, 32'h100, 1, 2'b10, 1);
    chk("lit sat low", 32'(bus.prediccionf), 32'h0);
    chk("lit mispredict flush", 32'(bus.flush), 32'h1);
    chk("lit mispredict pcfix", bus.pcfix, 32'h104);

    step(32'h100, 0, 0, 32'h0, 32'h100, 1, 2'b01, 1);
    chk("lit 10 nt -> 01", 32'(bus.prediccionf), 32'h1);
    chk("lit alias flush", 32'(bus.flush), 32'h1);
    chk("lit alias pcfix", bus.pcfix, 32'h104);

    step(32'h140, 1, 1, 32'h300, 32'h140, 0, 2'b00, 0);
    chk("lit alias cleared", 32'(m_hit(32'h100) | bus.hitf), 32'h0);
    chk("lit same-cycle 0x140 hitF", 32'(bus.hitf), 32'h0);

    step(32'h140, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0);
    chk("lit 0x140 next hitF", 32'(bus.hitf), 32'h1);
    chk("lit 0x140 pcbp", bus.pcbpf, 32'h300);
    chk("lit nbranch", nbranch, 32'd5);
    chk("lit nmiss", nmiss, 32'd4);
    chk("lit bubble flush", 32'(bus.flush), 32'h0);

    rand_cycles(3000);

    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("lit async nbranch", nbranch, 32'h0);
    chk("lit async nmiss", nmiss, 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus.pcf_addr = pool[i];
      #1;
      chk("lit async hitF", 32'(bus.hitf), 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    rand_cycles(500);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
